bl_mask_seq: RTL and testbench
==============================

# bl_mask_seq

Parametrised, sequenced bitline-mask generator for the configurable-width SRAM macro. It generalises the fixed 32/16/8 mask decode to any power-of-two word/segment split. It latches the width mode under a load strobe and accepts burst requests over a valid/ready handshake. It then emits one registered active-low bitline mask per beat, stepping the access group and flagging row crossings for the row decoder.

## Interface
Parameters:
- WORD_W, 32, physical bitline count per row; power of two.
- SEG_W, 8, narrowest access width; power of two, SEG_W <= WORD_W.
- BURST_W, 4, width of the burst-length field.
- Derived: NSEG = WORD_W/SEG_W; SEL_W = max(1, log2(NSEG)); CONF_W = max(1, clog2(SEL_W+1)).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- cfg_load  in  1  mode load strobe
- cfg_mode  in  CONF_W  requested mode m; access width = WORD_W >> m
- cfg_err  out  1  one-cycle pulse when a load is rejected
- mode  out  CONF_W  currently active mode
- req_valid  in  1  burst request valid
- req_ready  out  1  request accepted when high with req_valid
- req_sel  in  SEL_W  start group select; only the low m bits are used
- req_len  in  BURST_W  beats minus one
- mask_valid  out  1  beat output valid
- mask_ready  in  1  downstream accepts the beat
- bl_mask  out  WORD_W  bit = 0 means the column is enabled, 1 means masked
- mask_sel  out  SEL_W  group index of the current beat
- mask_row_inc  out  1  current beat wrapped to the next row
- mask_last  out  1  final beat of the burst

## Operation
- Mode m is legal when m <= SEL_W. This gives G = 2^m groups, each containing NSEG >> m segments.
- Group index is g = req_sel mod G.
- Segment s (bits s*SEG_W +: SEG_W) is enabled iff (s >> (SEL_W - m)) == g. Enabled bits are 0; all other bits are 1. In mode 0, all bits are 0.
- States:
  - IDLE: req_ready = !cfg_load.
  - BUSY: a beat is presented on the mask outputs.
- IDLE -> BUSY on a request handshake. The block captures g0 = req_sel mod G and len = req_len, and sets the beat count n = 0.
- Beat n:
  - g_n = (g0 + n) mod G.
  - mask_sel = g_n.
  - mask_row_inc = (n > 0) && (g_n == 0). In mode 0 this means every beat after the first.
  - mask_last = (n == len).
- On mask_valid && mask_ready: if mask_last, return to IDLE; otherwise n increments.
- cfg_load in IDLE:
  - Legal cfg_mode: mode is updated at the edge.
  - Illegal cfg_mode: mode is unchanged and cfg_err pulses.
- cfg_load in BUSY is ignored, and cfg_err pulses. Mode is constant for the whole burst.
- When cfg_load and req_valid arrive together in IDLE, the configuration wins: req_ready is 0 that cycle. The request is accepted on the next cycle under the new mode.
- When mask_valid = 0: bl_mask = all ones, and mask_sel, mask_row_inc and mask_last are 0.

## Timing
- Reset values: IDLE, mode = 0, req_ready = 1, mask_valid = 0, bl_mask = all ones, cfg_err = 0, all other outputs 0.
- Reset is asynchronous. Asserting it mid-burst aborts the burst immediately and forces the reset values; no beat completes.
- All outputs are registered except req_ready, which is combinational from state and cfg_load.
- Latency: mask_valid rises 1 cycle after the request handshake.
- Throughput: 1 beat per cycle while mask_ready is high.
- After the last beat handshake there is one IDLE cycle before the next mask_valid. The earliest next accept is in that cycle.
- While mask_valid && !mask_ready, all beat outputs hold stable.
- cfg_err is asserted in the cycle after the offending cfg_load, for exactly 1 cycle.
- Beat counter width is BURST_W. The maximum burst is 2^BURST_W beats, and n never wraps.

## Test plan
All scenarios use WORD_W=32, SEG_W=8, BURST_W=4.
- Reset: rst_n low, then high -> mode=0, req_ready=1, mask_valid=0, bl_mask=0xFFFFFFFF, cfg_err=0.
- Mode 0, req_sel=2, req_len=0 -> next cycle: mask_valid=1, bl_mask=0x00000000, mask_last=1, mask_row_inc=0. Then mask_valid=0 and one idle bubble.
- Load mode 1, then req_sel=1, req_len=2, mask_ready=1 -> three beats:
  - beat 0: bl_mask=0x0000FFFF, mask_sel=1, mask_row_inc=0.
  - beat 1: bl_mask=0xFFFF0000, mask_sel=0, mask_row_inc=1.
  - beat 2: bl_mask=0x0000FFFF, mask_last=1.
- Mode 2, req_sel=3, req_len=1, mask_ready low for 3 cycles -> bl_mask=0x00FFFFFF held stable with mask_valid=1. After mask_ready goes high: bl_mask=0xFFFFFF00, mask_row_inc=1, mask_last=1.
- Configuration events:
  - cfg_mode=3 (illegal) -> cfg_err pulses, mode unchanged.
  - cfg_load during a burst -> ignored, cfg_err pulses.
  - cfg_load with mode=2 together with req_valid in IDLE -> req_ready=0 that cycle. Mode=2 next cycle, and the request is accepted then.
- Reset mid-burst: rst_n asserted at beat 1 of a 4-beat burst -> outputs return to reset values asynchronously. After release, the next request starts cleanly with beat 0.

Source files
------------

// File: rtl/bl_mask_seq_if.sv
// Handshake bundle for bl_mask_seq: mode load, burst request and per-beat mask outputs.
// The master modport drives requests; the slave modport is the mask generator.
interface bl_mask_seq_if #(
  parameter int WORD_W  = 32,
  parameter int SEG_W   = 8,
  parameter int BURST_W = 4
);
  localparam int NSEG   = WORD_W / SEG_W;
  localparam int SEL_W  = ($clog2(NSEG) > 1) ? $clog2(NSEG) : 1;
  localparam int CONF_W = ($clog2(SEL_W + 1) > 1) ? $clog2(SEL_W + 1) : 1;

  logic              cfg_load;
  logic [CONF_W-1:0] cfg_mode;
  logic              cfg_err;
  logic [CONF_W-1:0] mode;
  logic              req_valid;
  logic              req_ready;
  logic [SEL_W-1:0]  req_sel;
  logic [BURST_W-1:0] req_len;
  logic              mask_valid;
  logic              mask_ready;
  logic [WORD_W-1:0] bl_mask;
  logic [SEL_W-1:0]  mask_sel;
  logic              mask_row_inc;
  logic              mask_last;

  modport master (
    output cfg_load, cfg_mode, req_valid, req_sel, req_len, mask_ready,
    input  cfg_err, mode, req_ready, mask_valid, bl_mask, mask_sel, mask_row_inc, mask_last
  );

  modport slave (
    input  cfg_load, cfg_mode, req_valid, req_sel, req_len, mask_ready,
    output cfg_err, mode, req_ready, mask_valid, bl_mask, mask_sel, mask_row_inc, mask_last
  );
endinterface

// File: rtl/bl_mask_seq.sv
// Sequenced active-low bitline-mask generator: latches a width mode, then walks
// access groups one beat per handshake, flagging wraps back to group 0 as row crossings.
module bl_mask_seq #(
  parameter int WORD_W  = 32,
  parameter int SEG_W   = 8,
  parameter int BURST_W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  bl_mask_seq_if.slave bus
);
  localparam int NSEG   = WORD_W / SEG_W;
  localparam int SEL_W  = ($clog2(NSEG) > 1) ? $clog2(NSEG) : 1;
  localparam int CONF_W = ($clog2(SEL_W + 1) > 1) ? $clog2(SEL_W + 1) : 1;

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  state_t              r_state;
  logic [CONF_W-1:0]   r_mode;
  logic                r_cfg_err;
  logic [BURST_W-1:0]  r_len;
  logic [BURST_W-1:0]  r_n;
  logic                r_mask_valid;
  logic [WORD_W-1:0]   r_bl_mask;
  logic [SEL_W-1:0]    r_mask_sel;
  logic                r_mask_row_inc;
  logic                r_mask_last;

  logic [SEL_W-1:0]    w_g0;
  logic [SEL_W-1:0]    w_g_next;
  logic [BURST_W-1:0]  w_n_next;

  // Low-m-bits mask: reduces a group index modulo G = 2^m.
  function automatic logic [SEL_W-1:0] f_grp_mask(input logic [CONF_W-1:0] m);
    logic [SEL_W-1:0] v;
    for (int b = 0; b < SEL_W; b++) v[b] = (b < int'(m));
    return v;
  endfunction

  function automatic logic [WORD_W-1:0] f_mask(input logic [CONF_W-1:0] m,
                                               input logic [SEL_W-1:0]  g);
    logic [WORD_W-1:0] v;
    int sh;
    v  = '1;
    sh = SEL_W - int'(m);
    for (int s = 0; s < NSEG; s++)
      if ((s >> sh) == int'(g)) v[s*SEG_W +: SEG_W] = '0;
    return v;
  endfunction

  assign w_g0     = bus.req_sel & f_grp_mask(r_mode);
  assign w_g_next = (r_mask_sel + SEL_W'(1)) & f_grp_mask(r_mode);
  assign w_n_next = r_n + BURST_W'(1);

  assign bus.req_ready    = (r_state == ST_IDLE) && !bus.cfg_load;
  assign bus.cfg_err      = r_cfg_err;
  assign bus.mode         = r_mode;
  assign bus.mask_valid   = r_mask_valid;
  assign bus.bl_mask      = r_bl_mask;
  assign bus.mask_sel     = r_mask_sel;
  assign bus.mask_row_inc = r_mask_row_inc;
  assign bus.mask_last    = r_mask_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_mode         <= '0;
      r_cfg_err      <= 1'b0;
      r_len          <= '0;
      r_n            <= '0;
      r_mask_valid   <= 1'b0;
      r_bl_mask      <= '1;
      r_mask_sel     <= '0;
      r_mask_row_inc <= 1'b0;
      r_mask_last    <= 1'b0;
    end else begin
      r_cfg_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // A config load takes priority; req_ready is low in that cycle.
          if (bus.cfg_load) begin
            if (bus.cfg_mode <= CONF_W'(SEL_W)) r_mode    <= bus.cfg_mode;
            else                                r_cfg_err <= 1'b1;
          end else if (bus.req_valid) begin
            r_state        <= ST_BUSY;
            r_len          <= bus.req_len;
            r_n            <= '0;
            r_mask_valid   <= 1'b1;
            r_bl_mask      <= f_mask(r_mode, w_g0);
            r_mask_sel     <= w_g0;
            r_mask_row_inc <= 1'b0;
            r_mask_last    <= (bus.req_len == '0);
          end
        end
        ST_BUSY: begin
          if (bus.cfg_load) r_cfg_err <= 1'b1;
          if (bus.mask_ready) begin
            if (r_mask_last) begin
              r_state        <= ST_IDLE;
              r_mask_valid   <= 1'b0;
              r_bl_mask      <= '1;
              r_mask_sel     <= '0;
              r_mask_row_inc <= 1'b0;
              r_mask_last    <= 1'b0;
            end else begin
              r_n            <= w_n_next;
              r_bl_mask      <= f_mask(r_mode, w_g_next);
              r_mask_sel     <= w_g_next;
              r_mask_row_inc <= (w_g_next == '0);
              r_mask_last    <= (w_n_next == r_len);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bl_mask_seq.sv
// Directed bench for bl_mask_seq with WORD_W=32, SEG_W=8, BURST_W=4; expected masks hand-derived.
module tb_bl_mask_seq;
  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_bad;

  bl_mask_seq_if #(.WORD_W(32), .SEG_W(8), .BURST_W(4)) bus ();

  bl_mask_seq #(.WORD_W(32), .SEG_W(8), .BURST_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input string tag, input logic [31:0] mask, input logic [31:0] sel,
                      input logic [31:0] row, input logic [31:0] last);
    chk({tag, " valid"}, 32'(bus.mask_valid), 32'd1);
    chk({tag, " mask"},  bus.bl_mask, mask);
    chk({tag, " sel"},   32'(bus.mask_sel), sel);
    chk({tag, " row"},   32'(bus.mask_row_inc), row);
    chk({tag, " last"},  32'(bus.mask_last), last);
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, " valid"}, 32'(bus.mask_valid), 32'd0);
    chk({tag, " mask"},  bus.bl_mask, 32'hFFFF_FFFF);
    chk({tag, " sel"},   32'(bus.mask_sel), 32'd0);
    chk({tag, " last"},  32'(bus.mask_last), 32'd0);
    chk({tag, " row"},   32'(bus.mask_row_inc), 32'd0);
  endtask

  task automatic load(input logic [1:0] m);
    bus.cfg_load = 1'b1;
    bus.cfg_mode = m;
    tick();
    bus.cfg_load = 1'b0;
  endtask

  task automatic request(input logic [1:0] sel, input logic [3:0] len);
    bus.req_valid = 1'b1;
    bus.req_sel   = sel;
    bus.req_len   = len;
    #1;
    chk("req_ready before accept", 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.cfg_load = 1'b0; bus.cfg_mode = '0;
    bus.req_valid = 1'b0; bus.req_sel = '0; bus.req_len = '0;
    bus.mask_ready = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    chk("rst mode",      32'(bus.mode),      32'd0);
    chk("rst req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst cfg_err",   32'(bus.cfg_err),   32'd0);
    idle_chk("rst");

    // Mode 0, single beat
    request(2'd2, 4'd0);
    beat("m0 b0", 32'h0000_0000, 32'd0, 32'd0, 32'd1);
    tick();
    idle_chk("m0 bubble");
    chk("m0 bubble ready", 32'(bus.req_ready), 32'd1);

    // Mode 1, three beats
    load(2'd1);
    chk("load m1 mode", 32'(bus.mode), 32'd1);
    chk("load m1 err",  32'(bus.cfg_err), 32'd0);
    request(2'd1, 4'd2);
    beat("m1 b0", 32'h0000_FFFF, 32'd1, 32'd0, 32'd0);
    tick();
    beat("m1 b1", 32'hFFFF_0000, 32'd0, 32'd1, 32'd0);
    tick();
    beat("m1 b2", 32'h0000_FFFF, 32'd1, 32'd0, 32'd1);
    tick();
    idle_chk("m1 end");

    // Mode 2 with downstream stall
    load(2'd2);
    chk("load m2 mode", 32'(bus.mode), 32'd2);
    bus.mask_ready = 1'b0;
    request(2'd3, 4'd1);
    beat("m2 stall0", 32'h00FF_FFFF, 32'd3, 32'd0, 32'd0);
    tick();
    beat("m2 stall1", 32'h00FF_FFFF, 32'd3, 32'd0, 32'd0);
    tick();
    beat("m2 stall2", 32'h00FF_FFFF, 32'd3, 32'd0, 32'd0);
    bus.mask_ready = 1'b1;
    tick();
    beat("m2 b1", 32'hFFFF_FF00, 32'd0, 32'd1, 32'd1);
    tick();
    idle_chk("m2 end");

    // Illegal mode rejected
    load(2'd3);
    chk("illegal err",  32'(bus.cfg_err), 32'd1);
    chk("illegal mode", 32'(bus.mode),    32'd2);
    tick();
    chk("illegal err pulse", 32'(bus.cfg_err), 32'd0);

    // Load during burst ignored
    request(2'd0, 4'd3);
    beat("busy b0", 32'hFFFF_FF00, 32'd0, 32'd0, 32'd0);
    load(2'd1);
    chk("busy load err",  32'(bus.cfg_err), 32'd1);
    chk("busy load mode", 32'(bus.mode),    32'd2);
    beat("busy b1", 32'hFFFF_00FF, 32'd1, 32'd0, 32'd0);
    tick();
    chk("busy err pulse", 32'(bus.cfg_err), 32'd0);
    beat("busy b2", 32'hFF00_FFFF, 32'd2, 32'd0, 32'd0);
    tick();
    beat("busy b3", 32'h00FF_FFFF, 32'd3, 32'd0, 32'd1);
    tick();
    idle_chk("busy end");

    // Load and request collide in IDLE: config wins
    load(2'd0);
    chk("pre-collide mode", 32'(bus.mode), 32'd0);
    bus.cfg_load  = 1'b1;
    bus.cfg_mode  = 2'd2;
    bus.req_valid = 1'b1;
    bus.req_sel   = 2'd1;
    bus.req_len   = 4'd0;
    #1;
    chk("collide req_ready", 32'(bus.req_ready), 32'd0);
    tick();
    bus.cfg_load = 1'b0;
    #1;
    chk("collide mode",      32'(bus.mode),       32'd2);
    chk("collide not taken", 32'(bus.mask_valid), 32'd0);
    chk("collide ready",     32'(bus.req_ready),  32'd1);
    tick();
    bus.req_valid = 1'b0;
    beat("collide b0", 32'hFFFF_00FF, 32'd1, 32'd0, 32'd1);
    tick();
    idle_chk("collide end");

    // Asynchronous reset mid-burst
    request(2'd0, 4'd3);
    tick();
    beat("rstmid b1", 32'hFFFF_00FF, 32'd1, 32'd0, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    idle_chk("rstmid async");
    chk("rstmid mode",  32'(bus.mode),      32'd0);
    chk("rstmid ready", 32'(bus.req_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    idle_chk("rstmid held");
    request(2'd2, 4'd1);
    beat("after rst b0", 32'h0000_0000, 32'd0, 32'd0, 32'd0);
    tick();
    beat("after rst b1", 32'h0000_0000, 32'd0, 32'd1, 32'd1);
    tick();
    idle_chk("after rst end");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
